// File: rtl/score_update_ctrl.sv
// score_update_ctrl
//   Schedules hit events from three requesters (UFO, alien, bonus) into a
//   digit-serial BCD score accumulator and publishes a tear-free snapshot of
//   the score to the digit renderer once per frame.
//
//   Each requester has a saturating pending counter. When the FSM is idle the
//   highest-priority non-empty requester (UFO > alien > bonus) is granted; its
//   two-digit BCD addend is then added one digit per cycle. An event costs
//   1 + NUM_DIGITS cycles. A carry out of the top digit clamps the score at
//   all nines.
//
// Ports
//   clk             system clock
//   resetN          synchronous active-low reset
//   startOfFrame    one-cycle pulse at frame start; requests a score snapshot
//   game_reset      synchronous clear of score, queues and flags (new game)
//   ufo_hit         event pulse, one event per high cycle
//   alien_hit       event pulse, one event per high cycle
//   bonus_hit       event pulse, one event per high cycle
//   score_digits    displayed score snapshot, digit0 in [3:0]
//   busy            high while an addition is in progress
//   pend_overflow   sticky, an event was lost to a full pending counter
//   score_saturated sticky, the accumulator clamped at all nines
module score_update_ctrl #(
    parameter int         NUM_DIGITS   = 5,
    parameter int         PEND_W       = 4,
    parameter logic [7:0] UFO_POINTS   = 8'h50,
    parameter logic [7:0] ALIEN_POINTS = 8'h10,
    parameter logic [7:0] BONUS_POINTS = 8'h05
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    game_reset,
    input  logic                    ufo_hit,
    input  logic                    alien_hit,
    input  logic                    bonus_hit,
    output logic [4*NUM_DIGITS-1:0] score_digits,
    output logic                    busy,
    output logic                    pend_overflow,
    output logic                    score_saturated
);

    localparam int SCORE_W = 4 * NUM_DIGITS;
    localparam int PAD_W   = SCORE_W - 8;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NUM_REQ = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {S_IDLE, S_ADD} state_t;

    state_t               state_reg, state_next;
    logic                 clr;
    logic [NUM_REQ-1:0]   ev, grant, pend_nz, drop;
    logic [SCORE_W-1:0]   acc_reg, acc_next;
    logic [SCORE_W-1:0]   add_reg, add_next;
    logic [SCORE_W-1:0]   score_reg;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 carry_reg, carry_next;
    logic                 sat_reg, sat_next;
    logic                 ovf_reg, busy_reg, defer_reg;
    logic [3:0]           acc_digit, add_digit;
    logic [4:0]           digit_sum, digit_wrap;
    logic                 carry_out;

    // game_reset behaves exactly like the hardware reset
    assign clr = !resetN || game_reset;
    assign ev  = {bonus_hit, alien_hit, ufo_hit};

    // Pending counters; index 0 = UFO, 1 = alien, 2 = bonus.
    // Event and grant together cancel; an event into a full counter is lost.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pend
            logic [PEND_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    cnt_reg <= '0;
                end else if (ev[gi] && !grant[gi]) begin
                    if (!(&cnt_reg)) begin
                        cnt_reg <= cnt_reg + PEND_W'(1);
                    end
                end else if (!ev[gi] && grant[gi]) begin
                    cnt_reg <= cnt_reg - PEND_W'(1);
                end
            end

            assign pend_nz[gi] = |cnt_reg;
            assign drop[gi]    = ev[gi] && !grant[gi] && (&cnt_reg);
        end
    endgenerate

    // Fixed-priority grant, only offered while idle
    always_comb begin
        grant = '0;
        if (state_reg == S_IDLE) begin
            if (pend_nz[0]) begin
                grant[0] = 1'b1;
            end else if (pend_nz[1]) begin
                grant[1] = 1'b1;
            end else if (pend_nz[2]) begin
                grant[2] = 1'b1;
            end
        end
    end

    // Current digit pair for the serial adder
    assign acc_digit  = acc_reg[4*idx_reg +: 4];
    assign add_digit  = add_reg[4*idx_reg +: 4];
    assign digit_sum  = {1'b0, acc_digit} + {1'b0, add_digit} + {4'b0000, carry_reg};
    assign digit_wrap = digit_sum - 5'd10;
    assign carry_out  = (digit_sum > 5'd9);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        add_next   = add_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        sat_next   = sat_reg;
        case (state_reg)
            S_IDLE: begin
                if (|grant) begin
                    state_next = S_ADD;
                    idx_next   = '0;
                    carry_next = 1'b0;
                    if (grant[0]) begin
                        add_next = {{PAD_W{1'b0}}, UFO_POINTS};
                    end else if (grant[1]) begin
                        add_next = {{PAD_W{1'b0}}, ALIEN_POINTS};
                    end else begin
                        add_next = {{PAD_W{1'b0}}, BONUS_POINTS};
                    end
                end
            end
            S_ADD: begin
                acc_next[4*idx_reg +: 4] = carry_out ? digit_wrap[3:0] : digit_sum[3:0];
                carry_next               = carry_out;
                if (idx_reg == LAST_IDX) begin
                    state_next = S_IDLE;
                    // Overflow out of the top digit: clamp rather than wrap
                    if (carry_out) begin
                        acc_next = {NUM_DIGITS{4'h9}};
                        sat_next = 1'b1;
                    end
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            add_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            sat_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            add_reg   <= add_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            sat_reg   <= sat_next;
            busy_reg  <= (state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_reg <= 1'b0;
        end else if (|drop) begin
            ovf_reg <= 1'b1;
        end
    end

    // Snapshot only while idle so the display never sees a half-added score.
    // A frame pulse during an addition is remembered and served on the first
    // idle cycle, even if that cycle also issues a new grant.
    always_ff @(posedge clk) begin
        if (clr) begin
            score_reg <= '0;
            defer_reg <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (startOfFrame || defer_reg) begin
                score_reg <= acc_reg;
                defer_reg <= 1'b0;
            end
        end else if (startOfFrame) begin
            defer_reg <= 1'b1;
        end
    end

    assign score_digits    = score_reg;
    assign busy            = busy_reg;
    assign pend_overflow   = ovf_reg;
    assign score_saturated = sat_reg;

endmodule

// File: tb/tb_score_update_ctrl.sv
// tb_score_update_ctrl
//   Drives two instances of score_update_ctrl (PEND_W = 4 and PEND_W = 8)
//   from the same inputs. Directed scenarios check against hand-derived
//   constants; a random phase checks every cycle against a transaction-level
//   model that tracks queue depths, a remaining-cycles timer and the score as
//   a plain integer.
module tb_score_update_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        game_reset = 1'b0;
    logic        ufo = 1'b0;
    logic        alien = 1'b0;
    logic        bonus = 1'b0;
    logic [19:0] sd4, sd8;
    logic        busy4, busy8, ovf4, ovf8, sat4, sat8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_update_ctrl #(.PEND_W(4)) dut4 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .game_reset(game_reset),
        .ufo_hit(ufo), .alien_hit(alien), .bonus_hit(bonus),
        .score_digits(sd4), .busy(busy4), .pend_overflow(ovf4), .score_saturated(sat4)
    );

    score_update_ctrl #(.PEND_W(8)) dut8 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .game_reset(game_reset),
        .ufo_hit(ufo), .alien_hit(alien), .bonus_hit(bonus),
        .score_digits(sd8), .busy(busy8), .pend_overflow(ovf8), .score_saturated(sat8)
    );

    // ---------------- reference model (index 0: PEND_W=4, 1: PEND_W=8) ----
    int m_pend [2][3];
    int m_score [2];
    int m_disp [2];
    int m_rem [2];
    int m_pts [2];
    bit m_ovf [2];
    bit m_sat [2];
    bit m_defer [2];
    int m_g, m_pmax;
    bit m_idle;
    bit m_ev [3];

    function automatic int pts_of(input int r);
        return (r == 0) ? 50 : ((r == 1) ? 10 : 5);
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [19:0] d);
        int v;
        v = 0;
        for (int i = 4; i >= 0; i--) v = v * 10 + int'(d[i*4 +: 4]);
        return v;
    endfunction

    always @(posedge clk) begin
        m_ev[0] = ufo;
        m_ev[1] = alien;
        m_ev[2] = bonus;
        for (int k = 0; k < 2; k++) begin
            m_pmax = (k == 0) ? 15 : 255;
            if (!resetN || game_reset) begin
                for (int r = 0; r < 3; r++) m_pend[k][r] = 0;
                m_score[k] = 0; m_disp[k] = 0; m_rem[k] = 0; m_pts[k] = 0;
                m_ovf[k] = 0; m_sat[k] = 0; m_defer[k] = 0;
            end else begin
                m_idle = (m_rem[k] == 0);
                m_g = -1;
                if (m_idle) begin
                    for (int r = 2; r >= 0; r--) if (m_pend[k][r] > 0) m_g = r;
                end
                for (int r = 0; r < 3; r++) begin
                    if (m_ev[r] && m_g != r && m_pend[k][r] == m_pmax) m_ovf[k] = 1;
                    else m_pend[k][r] += (m_ev[r] ? 1 : 0) - ((m_g == r) ? 1 : 0);
                end
                if (m_idle && (sof || m_defer[k])) begin
                    m_disp[k] = m_score[k];
                    m_defer[k] = 0;
                end else if (!m_idle && sof) begin
                    m_defer[k] = 1;
                end
                if (m_g >= 0) begin
                    m_rem[k] = 5;
                    m_pts[k] = pts_of(m_g);
                end else if (m_rem[k] > 0) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_score[k] += m_pts[k];
                        if (m_score[k] > 99999) begin
                            m_score[k] = 99999;
                            m_sat[k] = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    // Wait until both instances have been idle two cycles in a row
    task automatic wait_idle();
        int low = 0;
        int n = 0;
        while (low < 2 && n < 600) begin
            tick();
            n++;
            if (!busy4 && !busy8) low++;
            else low = 0;
        end
        checks++;
        if (low < 2) begin
            failures++;
            $display("FAIL wait_idle timeout busy4=%0b busy8=%0b required 0", busy4, busy8);
        end
    endtask

    task automatic do_hit(input int r);
        ufo = (r == 0);
        alien = (r == 1);
        bonus = (r == 2);
        tick();
        ufo = 1'b0; alien = 1'b0; bonus = 1'b0;
        wait_idle();
    endtask

    task automatic new_game();
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ufo = 1'b1; alien = 1'b1; bonus = 1'b1; sof = 1'b1;
            tick();
        end
        ufo = 1'b0; alien = 1'b0; bonus = 1'b0; sof = 1'b0;
        checks++;
        if ({sd4, busy4, ovf4, sat4} !== 23'd0) begin
            failures++;
            $display("FAIL reset_dut4 got sd=%h busy=%b ovf=%b sat=%b required all 0", sd4, busy4, ovf4, sat4);
        end
        checks++;
        if ({sd8, busy8, ovf8, sat8} !== 23'd0) begin
            failures++;
            $display("FAIL reset_dut8 got sd=%h busy=%b ovf=%b sat=%b required all 0", sd8, busy8, ovf8, sat8);
        end
        resetN = 1'b1;
        tick();
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_queued got busy=%b required 0", busy4);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_alien();
        alien = 1'b1;
        tick();
        alien = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (busy4 !== 1'b1) begin
                failures++;
                $display("FAIL alien_busy_high cycle=%0d got %b required 1", i, busy4);
            end
            tick();
        end
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL alien_busy_low got %b required 0", busy4);
        end
        checks++;
        if (sd4 !== 20'h00000) begin
            failures++;
            $display("FAIL alien_no_snapshot got %h required 00000", sd4);
        end
        snap();
        checks++;
        if (sd4 !== 20'h00010) begin
            failures++;
            $display("FAIL alien_score got %h required 00010", sd4);
        end
        $display("test_single_alien done score=%h", sd4);
    endtask

    task automatic test_priority();
        new_game();
        ufo = 1'b1; alien = 1'b1;
        tick();
        ufo = 1'b0; alien = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (busy4 !== 1'b1) begin
                failures++;
                $display("FAIL prio_busy_ufo cycle=%0d got %b required 1", i, busy4);
            end
        end
        tick();
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap got busy=%b required 0", busy4);
        end
        // Frame pulse in the idle cycle that grants the alien event
        snap();
        checks++;
        if (busy4 !== 1'b1 || sd4 !== 20'h00050) begin
            failures++;
            $display("FAIL prio_ufo_first got busy=%b sd=%h required busy=1 sd=00050", busy4, sd4);
        end
        for (int i = 8; i <= 11; i++) begin
            tick();
            checks++;
            if (busy4 !== 1'b1) begin
                failures++;
                $display("FAIL prio_busy_alien cycle=%0d got %b required 1", i, busy4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy4 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL prio_queues_empty cycle=%0d got busy4=%b busy8=%b required 0", i, busy4, busy8);
            end
        end
        snap();
        checks++;
        if (sd4 !== 20'h00060 || sd8 !== 20'h00060) begin
            failures++;
            $display("FAIL prio_total got sd4=%h sd8=%h required 00060", sd4, sd8);
        end
        $display("test_priority done score=%h", sd4);
    endtask

    task automatic test_deferred_snapshot();
        new_game();
        ufo = 1'b1;
        tick();
        ufo = 1'b0;
        tick();
        snap();
        checks++;
        if (sd4 !== 20'h00000 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL defer_held got sd=%h busy=%b required sd=00000 busy=1", sd4, busy4);
        end
        for (int i = 3; i <= 6; i++) begin
            tick();
            checks++;
            if (sd4 !== 20'h00000) begin
                failures++;
                $display("FAIL defer_no_tear cycle=%0d got %h required 00000", i, sd4);
            end
        end
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL defer_add_done got busy=%b required 0", busy4);
        end
        tick();
        checks++;
        if (sd4 !== 20'h00050) begin
            failures++;
            $display("FAIL defer_publish got %h required 00050", sd4);
        end
        $display("test_deferred_snapshot done score=%h", sd4);
    endtask

    task automatic test_carry_ripple();
        new_game();
        for (int i = 0; i < 199; i++) do_hit(0);
        for (int i = 0; i < 4; i++) do_hit(1);
        snap();
        checks++;
        if (sd4 !== 20'h09990) begin
            failures++;
            $display("FAIL ripple_pre got %h required 09990", sd4);
        end
        do_hit(1);
        snap();
        checks++;
        if (sd4 !== 20'h10000 || sd8 !== 20'h10000) begin
            failures++;
            $display("FAIL ripple_carry got sd4=%h sd8=%h required 10000", sd4, sd8);
        end
        $display("test_carry_ripple done score=%h", sd4);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 1799; i++) do_hit(0);
        for (int i = 0; i < 4; i++) do_hit(1);
        snap();
        checks++;
        if (sd4 !== 20'h99990 || sat4 !== 1'b0) begin
            failures++;
            $display("FAIL sat_pre got sd=%h sat=%b required sd=99990 sat=0", sd4, sat4);
        end
        do_hit(1);
        snap();
        checks++;
        if (sd4 !== 20'h99999 || sat4 !== 1'b1) begin
            failures++;
            $display("FAIL sat_clamp got sd=%h sat=%b required sd=99999 sat=1", sd4, sat4);
        end
        do_hit(0);
        snap();
        checks++;
        if (sd4 !== 20'h99999 || sat4 !== 1'b1 || sd8 !== 20'h99999 || sat8 !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold got sd4=%h sat4=%b sd8=%h sat8=%b required 99999 sat=1", sd4, sat4, sd8, sat8);
        end
        $display("test_saturate done score=%h", sd4);
    endtask

    task automatic test_game_reset_mid();
        // Overfill the UFO queue of the narrow instance, then clear mid-add
        ufo = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        ufo = 1'b0;
        checks++;
        if (ovf4 !== 1'b1 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL greset_pre got ovf=%b busy=%b required ovf=1 busy=1", ovf4, busy4);
        end
        tick();
        game_reset = 1'b1;
        bonus = 1'b1;
        tick();
        game_reset = 1'b0;
        bonus = 1'b0;
        checks++;
        if ({sd4, busy4, ovf4, sat4} !== 23'd0) begin
            failures++;
            $display("FAIL greset_clear got sd=%h busy=%b ovf=%b sat=%b required all 0", sd4, busy4, ovf4, sat4);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (busy4 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL greset_queues cycle=%0d got busy4=%b busy8=%b required 0", i, busy4, busy8);
            end
        end
        snap();
        checks++;
        if (sd4 !== 20'h00000 || sd8 !== 20'h00000) begin
            failures++;
            $display("FAIL greset_snapshot got sd4=%h sd8=%h required 00000", sd4, sd8);
        end
        $display("test_game_reset_mid done");
    endtask

    task automatic test_overflow();
        new_game();
        alien = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        alien = 1'b0;
        wait_idle();
        snap();
        checks++;
        if (ovf4 !== 1'b1 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flags got ovf4=%b ovf8=%b required ovf4=1 ovf8=0", ovf4, ovf8);
        end
        checks++;
        if (sd8 !== 20'h00300) begin
            failures++;
            $display("FAIL ovf_wide_score got %h required 00300", sd8);
        end
        checks++;
        if (from_bcd(sd4) >= 300 || sd4 !== to_bcd(m_disp[0])) begin
            failures++;
            $display("FAIL ovf_narrow_score got %h required %h (below 00300)", sd4, to_bcd(m_disp[0]));
        end
        $display("test_overflow done narrow=%h wide=%h", sd4, sd8);
    endtask

    task automatic test_random();
        logic [22:0] exp4, exp8;
        new_game();
        for (int c = 0; c < 800; c++) begin
            ufo        = ($urandom_range(0, 5) == 0);
            alien      = ($urandom_range(0, 2) == 0);
            bonus      = ($urandom_range(0, 6) == 0);
            sof        = ($urandom_range(0, 9) == 0);
            game_reset = ($urandom_range(0, 299) == 0);
            tick();
            exp4 = {to_bcd(m_disp[0]), (m_rem[0] > 0), m_ovf[0], m_sat[0]};
            exp8 = {to_bcd(m_disp[1]), (m_rem[1] > 0), m_ovf[1], m_sat[1]};
            checks++;
            if ({sd4, busy4, ovf4, sat4} !== exp4) begin
                failures++;
                $display("FAIL rand_dut4 cycle=%0d got sd=%h busy=%b ovf=%b sat=%b required sd=%h busy=%b ovf=%b sat=%b",
                         c, sd4, busy4, ovf4, sat4, exp4[22:3], exp4[2], exp4[1], exp4[0]);
            end
            checks++;
            if ({sd8, busy8, ovf8, sat8} !== exp8) begin
                failures++;
                $display("FAIL rand_dut8 cycle=%0d got sd=%h busy=%b ovf=%b sat=%b required sd=%h busy=%b ovf=%b sat=%b",
                         c, sd8, busy8, ovf8, sat8, exp8[22:3], exp8[2], exp8[1], exp8[0]);
            end
        end
        ufo = 1'b0; alien = 1'b0; bonus = 1'b0; sof = 1'b0; game_reset = 1'b0;
        $display("test_random done model_score4=%0d model_score8=%0d", m_score[0], m_score[1]);
    endtask

    initial begin
        test_reset();
        test_single_alien();
        test_priority();
        test_deferred_snapshot();
        test_carry_ripple();
        test_saturate();
        test_game_reset_mid();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
